// File: rtl/fwrisc_csr_pkg.sv
// rtl/fwrisc_csr_pkg.sv - shared fwrisc CSR addresses in the 6-bit register-file space
// CSRs live above the 32 GPRs in the unified register file; these are the
// slots the trap sequencer reads and writes.
package fwrisc_csr_pkg;

  localparam logic [5:0] CSR_MEPC   = 6'h29;
  localparam logic [5:0] CSR_MCAUSE = 6'h2A;

endpackage

// File: rtl/fwrisc_trap_pkg.sv
// rtl/fwrisc_trap_pkg.sv - trap sequencer FSM states, cause codes and PC alignment helper
package fwrisc_trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_EPC    = 3'd1,
    ST_WR_CAUSE  = 3'd2,
    ST_REDIR     = 3'd3,
    ST_RD_EPC    = 3'd4,
    ST_RET_REDIR = 3'd5
  } trap_state_e;

  // Machine external interrupt cause code
  localparam logic [3:0] CAUSE_M_EXT_IRQ = 4'd11;

  // Clear the two low bits of a PC / vector value
  function automatic logic [31:0] align4(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fwrisc_trap_seq.sv
// rtl/fwrisc_trap_seq.sv - trap entry / MRET sequencer in front of the fwrisc register file
// Purpose: on an exception or enabled external interrupt, writes mepc and
//   mcause through the register-file write port and redirects fetch to mtvec;
//   on MRET, reads mepc through read port B and redirects fetch to it.
// Ports:
//   clock, reset                        clock, synchronous active-high reset
//   exc_req, exc_cause, cur_pc          exception request, cause, PC to save
//   mret_req                            MRET retiring
//   irq, meie, mie, mtvec               interrupt line, enables, trap vector
//   core_rd_waddr/wdata/wen             core write port (passed through in IDLE)
//   rd_waddr/wdata/wen                  write port to the register file
//   core_rb_raddr, rb_raddr, rb_rdata   read-B address in/out, registered read data
//   trap, tret                          single-cycle pulses to the register file
//   redirect_valid, redirect_pc         fetch redirect
//   busy                                core stall while sequencing
// Configuration: define FWRISC_TRAP_VECTORED_EN to enable vectored interrupt
//   dispatch when mtvec[1:0]==2'b01.
module fwrisc_trap_seq
  import fwrisc_trap_pkg::*;
  import fwrisc_csr_pkg::*;
#(
  parameter int IRQ_CAUSE = int'(CAUSE_M_EXT_IRQ)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exc_req,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] cur_pc,
  input  logic        mret_req,
  input  logic        irq,
  input  logic        meie,
  input  logic        mie,
  input  logic [31:0] mtvec,
  input  logic [5:0]  core_rd_waddr,
  input  logic [31:0] core_rd_wdata,
  input  logic        core_rd_wen,
  output logic [5:0]  rd_waddr,
  output logic [31:0] rd_wdata,
  output logic        rd_wen,
  input  logic [5:0]  core_rb_raddr,
  output logic [5:0]  rb_raddr,
  input  logic [31:0] rb_rdata,
  output logic        trap,
  output logic        tret,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  trap_state_e r_state;
  logic [31:0] r_pc;
  logic [3:0]  r_cause;
  logic        r_int;
  logic        r_fsm_wen;
  logic [5:0]  r_fsm_waddr;
  logic [5:0]  r_rb_raddr;
  logic        r_trap;
  logic        r_tret;
  logic        r_redir_valid;

  logic        w_irq_take;
  logic        w_take_trap;
  logic [31:0] w_vec_pc;

  assign w_irq_take  = irq & meie & mie;
  assign w_take_trap = exc_req | w_irq_take;

`ifdef FWRISC_TRAP_VECTORED_EN
  // Only interrupts dispatch through the vector table; exceptions use the base
  assign w_vec_pc = (r_int && (mtvec[1:0] == 2'b01))
                    ? align4(mtvec) + {26'b0, r_cause, 2'b00}
                    : align4(mtvec);
`else
  assign w_vec_pc = align4(mtvec);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_cause       <= '0;
      r_int         <= 1'b0;
      r_fsm_wen     <= 1'b0;
      r_fsm_waddr   <= '0;
      r_rb_raddr    <= '0;
      r_trap        <= 1'b0;
      r_tret        <= 1'b0;
      r_redir_valid <= 1'b0;
    end else begin
      r_fsm_wen     <= 1'b0;
      r_trap        <= 1'b0;
      r_tret        <= 1'b0;
      r_redir_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take_trap) begin
            // Exception wins over interrupt, and either wins over MRET
            r_pc        <= cur_pc;
            r_cause     <= exc_req ? exc_cause : 4'(IRQ_CAUSE);
            r_int       <= ~exc_req;
            r_state     <= ST_WR_EPC;
            r_fsm_wen   <= 1'b1;
            r_fsm_waddr <= CSR_MEPC;
            r_trap      <= 1'b1;
          end else if (mret_req) begin
            r_state    <= ST_RD_EPC;
            r_rb_raddr <= CSR_MEPC;
          end
        end
        ST_WR_EPC: begin
          r_state     <= ST_WR_CAUSE;
          r_fsm_wen   <= 1'b1;
          r_fsm_waddr <= CSR_MCAUSE;
        end
        ST_WR_CAUSE: begin
          r_state       <= ST_REDIR;
          r_redir_valid <= 1'b1;
        end
        ST_RD_EPC: begin
          // mepc read data arrives next cycle from the registered read port
          r_state       <= ST_RET_REDIR;
          r_tret        <= 1'b1;
          r_redir_valid <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);

  // Strobes are masked by reset so a sequence cut short issues nothing more
  assign rd_wen         = busy ? (r_fsm_wen & ~reset) : core_rd_wen;
  assign rd_waddr       = busy ? r_fsm_waddr : core_rd_waddr;
  assign rd_wdata       = !busy                  ? core_rd_wdata :
                          (r_state == ST_WR_EPC) ? align4(r_pc) :
                                                   {r_int, 27'b0, r_cause};
  assign rb_raddr       = busy ? r_rb_raddr : core_rb_raddr;
  assign trap           = r_trap & ~reset;
  assign tret           = r_tret & ~reset;
  assign redirect_valid = r_redir_valid & ~reset;
  assign redirect_pc    = (r_state == ST_RET_REDIR) ? align4(rb_rdata) : w_vec_pc;

endmodule

// File: tb/tb_fwrisc_trap_seq.sv
// tb/tb_fwrisc_trap_seq.sv - directed self-checking bench for fwrisc_trap_seq
module tb_fwrisc_trap_seq;
  import fwrisc_csr_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        exc_req = 1'b0;
  logic [3:0]  exc_cause = '0;
  logic [31:0] cur_pc = '0;
  logic        mret_req = 1'b0;
  logic        irq = 1'b0;
  logic        meie = 1'b0;
  logic        mie = 1'b0;
  logic [31:0] mtvec = 32'h200;
  logic [5:0]  core_rd_waddr = '0;
  logic [31:0] core_rd_wdata = '0;
  logic        core_rd_wen = 1'b0;
  logic [5:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        rd_wen;
  logic [5:0]  core_rb_raddr = '0;
  logic [5:0]  rb_raddr;
  logic [31:0] rb_rdata;
  logic        trap;
  logic        tret;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int total = 0;
  int bad = 0;
  int n_trap = 0;
  int n_tret = 0;
  int n_mcause_wr = 0;
  int n_redir = 0;
  logic [31:0] exp_vec_irq;
  logic [31:0] rf [0:63];

  fwrisc_trap_seq dut (
    .clock(clock), .reset(reset),
    .exc_req(exc_req), .exc_cause(exc_cause), .cur_pc(cur_pc),
    .mret_req(mret_req), .irq(irq), .meie(meie), .mie(mie), .mtvec(mtvec),
    .core_rd_waddr(core_rd_waddr), .core_rd_wdata(core_rd_wdata), .core_rd_wen(core_rd_wen),
    .rd_waddr(rd_waddr), .rd_wdata(rd_wdata), .rd_wen(rd_wen),
    .core_rb_raddr(core_rb_raddr), .rb_raddr(rb_raddr), .rb_rdata(rb_rdata),
    .trap(trap), .tret(tret), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy)
  );

  always #5 clock = ~clock;

  // Register-file model: write port plus one-cycle registered read port B
  always @(posedge clock) begin
    if (rd_wen) rf[rd_waddr] <= rd_wdata;
    rb_rdata <= rf[rb_raddr];
    if (trap) n_trap <= n_trap + 1;
    if (tret) n_tret <= n_tret + 1;
    if (redirect_valid) n_redir <= n_redir + 1;
    if (rd_wen && rd_waddr == CSR_MCAUSE) n_mcause_wr <= n_mcause_wr + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
`ifdef FWRISC_TRAP_VECTORED_EN
    exp_vec_irq = 32'h32C;
`else
    exp_vec_irq = 32'h300;
`endif
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_trap", trap, 0);
    chk("rst_tret", tret, 0);
    chk("rst_redir", redirect_valid, 0);

    // Exception, with a core write/read in the accept cycle
    exc_req = 1; exc_cause = 4'd2; cur_pc = 32'h104; mtvec = 32'h200;
    core_rd_wen = 1; core_rd_waddr = 6'd5; core_rd_wdata = 32'hAAAA5555; core_rb_raddr = 6'd7;
    #1;
    chk("acc_busy", busy, 0);
    chk("acc_wen_pass", rd_wen, 1);
    chk("acc_waddr_pass", rd_waddr, 6'd5);
    chk("acc_wdata_pass", rd_wdata, 32'hAAAA5555);
    chk("acc_rb_pass", rb_raddr, 6'd7);
    cyc();
    exc_req = 0;
    #1;
    chk("exc_busy1", busy, 1);
    chk("exc_trap", trap, 1);
    chk("exc_epc_wen", rd_wen, 1);
    chk("exc_epc_addr", rd_waddr, CSR_MEPC);
    chk("exc_epc_data", rd_wdata, 32'h104);
    chk("exc_redir_early", redirect_valid, 0);
    cyc(); #1;
    chk("exc_trap_off", trap, 0);
    chk("exc_cause_wen", rd_wen, 1);
    chk("exc_cause_addr", rd_waddr, CSR_MCAUSE);
    chk("exc_cause_data", rd_wdata, 32'h2);
    cyc(); #1;
    chk("exc_redir_v", redirect_valid, 1);
    chk("exc_redir_pc", redirect_pc, 32'h200);
    chk("exc_core_wen_blocked", rd_wen, 0);
    chk("exc_busy3", busy, 1);
    cyc();
    core_rd_wen = 0;
    #1;
    chk("exc_ready", busy, 0);
    chk("exc_redir_off", redirect_valid, 0);

    // Interrupt masking, then a single entry on a held level
    irq = 1; meie = 0; mie = 1; cur_pc = 32'h80;
    cyc(); #1;
    chk("irq_meie_mask", busy, 0);
    meie = 1; mie = 0;
    cyc(); #1;
    chk("irq_mie_mask", busy, 0);
    mie = 1;
    cyc();
    mie = 0;
    #1;
    chk("irq_trap", trap, 1);
    chk("irq_epc_data", rd_wdata, 32'h80);
    cyc(); #1;
    chk("irq_cause_data", rd_wdata, 32'h8000000B);
    cyc(); #1;
    chk("irq_redir_pc", redirect_pc, 32'h200);
    repeat (5) cyc();
    #1;
    chk("irq_single_entry", n_trap, 2);
    chk("irq_idle", busy, 0);
    irq = 0; mie = 1;

    // MRET: preload mepc through the core write port
    core_rd_wen = 1; core_rd_waddr = CSR_MEPC; core_rd_wdata = 32'h1237;
    cyc();
    core_rd_wen = 0; mret_req = 1;
    #1;
    chk("mret_acc_busy", busy, 0);
    cyc();
    mret_req = 0;
    #1;
    chk("mret_rb_addr", rb_raddr, CSR_MEPC);
    chk("mret_tret_early", tret, 0);
    cyc(); #1;
    chk("mret_tret", tret, 1);
    chk("mret_redir_v", redirect_valid, 1);
    chk("mret_redir_pc", redirect_pc, 32'h1234);
    cyc(); #1;
    chk("mret_ready", busy, 0);

    // Priority: all three requests together
    exc_req = 1; exc_cause = 4'd3; cur_pc = 32'h40; irq = 1; meie = 1; mie = 1; mret_req = 1;
    cyc();
    exc_req = 0; irq = 0; mie = 0; mret_req = 0;
    #1;
    chk("prio_trap", trap, 1);
    chk("prio_epc", rd_wdata, 32'h40);
    cyc(); #1;
    chk("prio_cause", rd_wdata, 32'h3);
    cyc(); #1;
    chk("prio_redir", redirect_pc, 32'h200);
    cyc(); cyc(); #1;
    chk("prio_mret_dropped", busy, 0);
    chk("prio_tret_count", n_tret, 1);
    mie = 1;

    // Vectored mtvec mode
    mtvec = 32'h301; irq = 1; cur_pc = 32'h90;
    cyc();
    irq = 0; mie = 0;
    cyc(); cyc(); #1;
    chk("vec_irq_redir", redirect_pc, exp_vec_irq);
    cyc();
    mie = 1; exc_req = 1; exc_cause = 4'd5;
    cyc();
    exc_req = 0;
    cyc(); #1;
    chk("vec_exc_cause", rd_wdata, 32'h5);
    cyc(); #1;
    chk("vec_exc_redir", redirect_pc, 32'h300);
    cyc();

    // Reset in WR_CAUSE
    mtvec = 32'h200; exc_req = 1; exc_cause = 4'd7; cur_pc = 32'h500;
    cyc();
    exc_req = 0;
    cyc();
    reset = 1;
    #1;
    chk("rst_mid_wen", rd_wen, 0);
    chk("rst_mid_redir", redirect_valid, 0);
    cyc();
    reset = 0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_redir2", redirect_valid, 0);
    chk("rst_mid_wen2", rd_wen, 0);
    cyc(); cyc(); #1;
    chk("rst_mid_epc_stands", rf[CSR_MEPC], 32'h500);
    chk("mcause_write_count", n_mcause_wr, 5);
    chk("redirect_count", n_redir, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
